shift_unit_seq: RTL and testbench
=================================

// Module: shift_unit_seq
// PURPOSE
//  Multi-cycle shifter sitting directly downstream of the 5->32 shift-amount zero-extender.
//  Consumes the zero-extended shamt and a 32-bit operand; performs SLL/SRL/SRA iteratively.
//  Uses a start/busy/done handshake toward the execute-stage controller.
//  Trades latency for area versus a single-cycle barrel shifter.
// PARAMETERS
//  WIDTH  32  operand/result width; shift count always taken from shamt_ext[4:0]
//  STEP   1   max bit positions shifted per cycle; legal values 1,2,4,8
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  start      in   1      request; sampled only in IDLE
//  op         in   2      00 SLL, 01 SRL, 10 SRA, 11 see CONFIGURATION
//  data       in   WIDTH  operand to shift
//  shamt_ext  in   32     zero-extended shift amount; bits [31:5] ignored
//  busy       out  1      high in SHIFT and DONE
//  done       out  1      one-cycle pulse: result valid
//  result     out  WIDTH  shifted value; held until next accepted start
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, busy=0, done=0, result=0, cnt=0. Aborts any op.
//  - IDLE: start=1 -> latch data into acc, op, cnt=shamt_ext[4:0];
//    next = SHIFT if cnt!=0, else DONE. start=0 -> stay.
//  - SHIFT: each cycle s=min(STEP,cnt); acc shifted by s per op; cnt-=s.
//    Move to DONE on the edge where cnt reaches 0.
//  - DONE: result<=acc and done=1 for exactly one cycle; next IDLE, busy drops.
//  - Latency: start sampled at edge E -> done high in cycle after edge E+ceil(n/STEP)+1
//    (n=shamt[4:0]). n=0 -> done after edge E+1. Result registered at the same edge.
//  - SLL fills 0 from LSB; SRL fills 0 from MSB; SRA replicates acc[WIDTH-1] every step.
//  - start while busy (SHIFT/DONE): ignored, no queuing. data/op/shamt changes mid-op have no effect.
//  - done and start in the same cycle: start ignored (DONE counts as busy); accepted next cycle.
//  - Shift count never exceeds 31; no overflow/underflow on cnt.
// CONFIGURATION
//  SHIFT_ROTATE_EN defined:   op=11 is rotate-right by n (bits from LSB re-enter at MSB).
//  SHIFT_ROTATE_EN undefined: op=11 is no-op; result=data, completes with n=0 latency
//    regardless of shamt.
// TESTING
//  1 STEP=1, SLL data=0x00000001 shamt_ext=0x0000001F -> result=0x80000000, done 32 cycles after start.
//  2 SRA data=0x80000000 shamt_ext=0x00000004 -> 0xF8000000; SRL same inputs -> 0x08000000.
//  3 shamt_ext=0x00000000, op=SLL, data=0x1234ABCD -> result=0x1234ABCD, done 1 cycle after start.
//  4 shamt_ext=0xFFFFFFE1 (n=1), SLL data=0x00000003 -> 0x00000006; upper bits ignored.
//  5 start pulsed again during SHIFT with other data -> ignored; result from first op; one done pulse.
//  6 rst asserted mid-SHIFT -> busy=0, done=0, result=0 immediately; next start runs normally.
//  7 SHIFT_ROTATE_EN: op=11 data=0x00000001 n=1 -> 0x80000000; without macro -> 0x00000001.
//  8 STEP=4, SRL n=31 data=0xFFFFFFFF -> 0x00000001, done after 8 SHIFT cycles + 1.

Source files
------------

// File: rtl/shift_unit_seq.sv
// Iterative SLL/SRL/SRA shifter with start/busy/done handshake, up to STEP bits per cycle.
// Optional SHIFT_ROTATE_EN: op=11 rotates right; otherwise op=11 passes data through unchanged.
module shift_unit_seq #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data,
    input  logic [31:0]      shamt_ext,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    // state | meaning
    // IDLE  | waiting for start; busy=0
    // SHIFT | shifting acc; the cycle with cnt==0 commits result and raises done
    // DONE  | done pulse cycle; start still ignored here
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [4:0] STEP_AMT = 5'(STEP);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [1:0]       op_q;
    logic [4:0]       cnt;
    logic [4:0]       s;
    logic [4:0]       cnt_init;
    logic             unused_shamt;

    assign unused_shamt = ^shamt_ext[31:5];

    always_comb begin
        s = (cnt < STEP_AMT) ? cnt : STEP_AMT;
        acc_next = acc;
        case (op_q)
            2'b00:   acc_next = acc << s;
            2'b01:   acc_next = acc >> s;
            2'b10:   acc_next = $unsigned($signed(acc) >>> s);
`ifdef SHIFT_ROTATE_EN
            2'b11:   acc_next = (acc >> s) | (acc << (WIDTH - int'(s)));
`else
            2'b11:   acc_next = acc;
`endif
            default: acc_next = acc;
        endcase
    end

    // Without rotate support op=11 completes with zero-shift latency.
    always_comb begin
`ifdef SHIFT_ROTATE_EN
        cnt_init = shamt_ext[4:0];
`else
        cnt_init = (op == 2'b11) ? 5'd0 : shamt_ext[4:0];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            acc    <= '0;
            op_q   <= 2'b00;
            cnt    <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        acc   <= data;
                        op_q  <= op;
                        cnt   <= cnt_init;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt == 5'd0) begin
                        result <= acc;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt - s;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed self-checking bench for shift_unit_seq (STEP=1 and STEP=4 instances).
module tb_shift_unit_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start, start4;
    logic [1:0]  op, op4;
    logic [31:0] data, data4, shamt, shamt4;
    logic        busy, done, busy4, done4;
    logic [31:0] result, result4;
    int          checks = 0;
    int          errors = 0;
    int          lat;
    int          pulses;
    logic [31:0] got;

    always #5 clk = ~clk;

    shift_unit_seq #(.WIDTH(32), .STEP(1)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .data(data),
        .shamt_ext(shamt), .busy(busy), .done(done), .result(result));

    shift_unit_seq #(.WIDTH(32), .STEP(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .op(op4), .data(data4),
        .shamt_ext(shamt4), .busy(busy4), .done(done4), .result(result4));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch one op on the selected instance and measure edges from the start edge to done.
    task automatic run(input bit sel, input logic [1:0] o, input logic [31:0] d,
                       input logic [31:0] n, input logic [31:0] exp_res,
                       input int exp_lat, input string tag);
        @(negedge clk);
        if (sel) begin start4 = 1; op4 = o; data4 = d; shamt4 = n; end
        else     begin start  = 1; op  = o; data  = d; shamt  = n; end
        @(posedge clk); #1;
        start = 0; start4 = 0;
        check({tag, "_busy"}, 32'(sel ? busy4 : busy), 32'd1);
        lat = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            lat++;
            if (sel ? done4 : done) break;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, sel ? result4 : result, exp_res);
        @(posedge clk); #1;
        check({tag, "_done_clr"}, 32'(sel ? done4 : done), 32'd0);
        check({tag, "_busy_clr"}, 32'(sel ? busy4 : busy), 32'd0);
    endtask

    initial begin
        rst = 1; start = 0; start4 = 0; op = 0; op4 = 0;
        data = 0; data4 = 0; shamt = 0; shamt4 = 0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 0;

        run(0, 2'b00, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 32, "sll31");
        run(0, 2'b10, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 5, "sra4");
        run(0, 2'b01, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 5, "srl4");
        run(0, 2'b00, 32'h1234_ABCD, 32'h0000_0000, 32'h1234_ABCD, 1, "n0");
        run(0, 2'b00, 32'h0000_0003, 32'hFFFF_FFE1, 32'h0000_0006, 2, "upper_ign");
`ifdef SHIFT_ROTATE_EN
        run(0, 2'b11, 32'h0000_0001, 32'h0000_0001, 32'h8000_0000, 2, "op11");
`else
        run(0, 2'b11, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 1, "op11");
        run(0, 2'b11, 32'hCAFE_0001, 32'h0000_001F, 32'hCAFE_0001, 1, "op11_n31");
`endif

        // start re-pulsed mid-shift with different operands must be ignored
        @(negedge clk); start = 1; op = 2'b01; data = 32'h0000_00F0; shamt = 32'd4;
        @(negedge clk); start = 1; op = 2'b00; data = 32'h0000_AAAA; shamt = 32'd1;
        @(negedge clk); @(negedge clk); start = 0;
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            if (done) begin pulses++; got = result; end
        end
        check("restart_pulses", 32'(pulses), 32'd1);
        check("restart_res", got, 32'h0000_000F);

        // async reset in the middle of a shift
        @(negedge clk); start = 1; op = 2'b00; data = 32'h0000_0001; shamt = 32'd20;
        @(negedge clk); start = 0;
        repeat (5) @(negedge clk);
        #2 rst = 1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_result", result, 32'd0);
        @(negedge clk); rst = 0;
        run(0, 2'b01, 32'h0000_0100, 32'h0000_0008, 32'h0000_0001, 9, "after_rst");

        // start held through done: ignored in the done cycle, accepted the cycle after
        @(negedge clk); start = 1; op = 2'b00; data = 32'h0000_0001; shamt = 32'd2;
        @(posedge clk); #1;
        data = 32'h0000_0008; shamt = 32'd0;
        lat = 0; pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done) begin
                pulses++;
                if (pulses == 1) check("hold_first_lat", 32'(lat), 32'd3);
                if (pulses == 1) check("hold_first_res", result, 32'h0000_0004);
                if (pulses == 2) check("hold_second_lat", 32'(lat), 32'd6);
                if (pulses == 2) check("hold_second_res", result, 32'h0000_0008);
                if (pulses == 2) start = 0;
            end
        end
        start = 0;
        check("hold_pulses", 32'(pulses), 32'd2);
        repeat (3) @(posedge clk);

        run(1, 2'b01, 32'hFFFF_FFFF, 32'h0000_001F, 32'h0000_0001, 9, "s4_srl31");
        run(1, 2'b10, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 9, "s4_sra31");
        run(1, 2'b00, 32'h0000_0001, 32'h0000_0005, 32'h0000_0020, 3, "s4_sll5");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
